// File: rtl/multicycle_control_unit_pkg.sv
// Shared constants for the RV32I multi-cycle control unit: opcodes, ALU codes and FSM states.
package multicycle_control_unit_pkg;

   localparam logic [6:0] OP_TYPE_R = 7'b0110011;
   localparam logic [6:0] OP_TYPE_I = 7'b0010011;
   localparam logic [6:0] OP_TYPE_L = 7'b0000011;
   localparam logic [6:0] OP_TYPE_S = 7'b0100011;
   localparam logic [6:0] OP_TYPE_B = 7'b1100011;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b1000;
   localparam logic [3:0] ALU_SLL  = 4'b0001;
   localparam logic [3:0] ALU_SLT  = 4'b0010;
   localparam logic [3:0] ALU_SLTU = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SRL  = 4'b0101;
   localparam logic [3:0] ALU_SRA  = 4'b1101;
   localparam logic [3:0] ALU_OR   = 4'b0110;
   localparam logic [3:0] ALU_AND  = 4'b0111;
   localparam logic [3:0] ALU_BEQ  = 4'b1001;

   typedef enum logic [2:0] {
      ST_FETCH   = 3'd0,
      ST_DECODE  = 3'd1,
      ST_EXECUTE = 3'd2,
      ST_MEM     = 3'd3,
      ST_WB      = 3'd4,
      ST_TRAP    = 3'd5
   } state_e;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control bus between the sequencer and the IR / data memory / datapath.
interface multicycle_control_unit_if #(
   parameter int CNT_W = 32
);
   logic [31:0]      instrCode;
   logic             compare;
   logic             dataReady;
   logic             instrEn;
   logic             pcEn;
   logic             regFileWe;
   logic [3:0]       aluControl;
   logic             aluSrcMuxSel;
   logic             wdataSel;
   logic             PCAddrSrcMuxSel;
   logic             dataReq;
   logic             dataWe;
   logic             illegal;
   logic [CNT_W-1:0] instret;

   modport master (
      input  instrCode, compare, dataReady,
      output instrEn, pcEn, regFileWe, aluControl, aluSrcMuxSel, wdataSel,
             PCAddrSrcMuxSel, dataReq, dataWe, illegal, instret
   );

   modport slave (
      output instrCode, compare, dataReady,
      input  instrEn, pcEn, regFileWe, aluControl, aluSrcMuxSel, wdataSel,
             PCAddrSrcMuxSel, dataReq, dataWe, illegal, instret
   );
endinterface

// File: rtl/multicycle_control_unit_alu_decoder.sv
// Combinational opcode/func3/func7 decode into ALU operation, operand-B select and legality.
module alu_decoder
   import multicycle_control_unit_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] func3,
   input  logic       func7_5,
   output logic [3:0] alu_control,
   output logic       alu_src,
   output logic       legal
);

   always_comb begin
      alu_control = ALU_ADD;
      alu_src     = 1'b0;
      legal       = 1'b0;
      case (opcode)
         OP_TYPE_R: begin
            alu_control = {func7_5, func3};
            legal       = 1'b1;
         end
         OP_TYPE_I: begin
            // only SRAI/SRLI use imm[10] as an opcode bit; elsewhere it is immediate data
            alu_control = (func3 == 3'b101) ? {func7_5, func3} : {1'b0, func3};
            alu_src     = 1'b1;
            legal       = 1'b1;
         end
         OP_TYPE_L, OP_TYPE_S: begin
            alu_control = ALU_ADD;
            alu_src     = 1'b1;
            legal       = 1'b1;
         end
         OP_TYPE_B: begin
            case (func3[2:1])
               2'b10:   alu_control = ALU_SLT;
               2'b11:   alu_control = ALU_SLTU;
               default: alu_control = ALU_BEQ;
            endcase
            legal = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXECUTE/MEM/WB FSM, memory timeout and retire counter.
module multicycle_control_unit
   import multicycle_control_unit_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic                        clk,
   input  logic                        reset,
   multicycle_control_unit_if.master   bus
);

   localparam logic [2:0] FETCH   = ST_FETCH;
   localparam logic [2:0] DECODE  = ST_DECODE;
   localparam logic [2:0] EXECUTE = ST_EXECUTE;
   localparam logic [2:0] MEM     = ST_MEM;
   localparam logic [2:0] WB      = ST_WB;
   localparam logic [2:0] TRAP    = ST_TRAP;
   localparam int         TO_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

   logic [2:0]       state_reg, state_next;
   logic [TO_W-1:0]  timeout_reg, timeout_next;
   logic [CNT_W-1:0] instret_reg, instret_next;

   logic [6:0] opcode;
   logic [3:0] dec_alu;
   logic       dec_src, dec_legal;
   logic       is_load, is_store, is_branch, timeout_hit, taken;
   logic       unused_bits;

   assign opcode      = bus.instrCode[6:0];
   assign is_load     = (opcode == OP_TYPE_L);
   assign is_store    = (opcode == OP_TYPE_S);
   assign is_branch   = (opcode == OP_TYPE_B);
   assign taken       = bus.compare ^ bus.instrCode[12];
   assign unused_bits = ^{bus.instrCode[31], bus.instrCode[29:15], bus.instrCode[11:7]};
   assign timeout_hit = (MEM_TIMEOUT != 0) && !bus.dataReady
                        && (timeout_reg == TO_W'(MEM_TIMEOUT - 1));

   alu_decoder u_alu_decoder (
      .opcode      (opcode),
      .func3       (bus.instrCode[14:12]),
      .func7_5     (bus.instrCode[30]),
      .alu_control (dec_alu),
      .alu_src     (dec_src),
      .legal       (dec_legal)
   );

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         FETCH:   state_next = DECODE;
         DECODE:  state_next = dec_legal ? EXECUTE : TRAP;
         EXECUTE: state_next = is_branch ? FETCH : ((is_load || is_store) ? MEM : WB);
         MEM: begin
            if (bus.dataReady)
               state_next = is_store ? FETCH : WB;
            else if (timeout_hit)
               state_next = TRAP;
         end
         WB:      state_next = FETCH;
         TRAP:    state_next = TRAP;
         default: state_next = TRAP;
      endcase
   end

   // counter only runs while waiting inside MEM; any exit clears it
   assign timeout_next = (state_reg == MEM && state_next == MEM && MEM_TIMEOUT != 0)
                         ? timeout_reg + TO_W'(1) : '0;

   always_comb begin
      bus.instrEn         = 1'b0;
      bus.pcEn            = 1'b0;
      bus.regFileWe       = 1'b0;
      bus.aluControl      = 4'b0000;
      bus.aluSrcMuxSel    = 1'b0;
      bus.wdataSel        = 1'b0;
      bus.PCAddrSrcMuxSel = 1'b0;
      bus.dataReq         = 1'b0;
      bus.dataWe          = 1'b0;
      bus.illegal         = 1'b0;
      if (reset) begin
         if (state_reg inside {DECODE, EXECUTE, MEM, WB}) begin
            bus.aluControl   = dec_alu;
            bus.aluSrcMuxSel = dec_src;
         end
         case (state_reg)
            FETCH:   bus.instrEn = 1'b1;
            EXECUTE: begin
               if (is_branch) begin
                  bus.pcEn            = 1'b1;
                  bus.PCAddrSrcMuxSel = taken;
               end
            end
            MEM: begin
               bus.dataReq = 1'b1;
               bus.dataWe  = is_store;
               bus.pcEn    = is_store && bus.dataReady;
            end
            WB: begin
               bus.regFileWe = 1'b1;
               bus.wdataSel  = is_load;
               bus.pcEn      = 1'b1;
            end
            TRAP:    bus.illegal = 1'b1;
            default: ;
         endcase
      end
   end

   // every retirement is marked by exactly one pcEn pulse
   assign instret_next = instret_reg + CNT_W'(bus.pcEn);
   assign bus.instret  = instret_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg   <= FETCH;
         timeout_reg <= '0;
         instret_reg <= '0;
      end else begin
         state_reg   <= state_next;
         timeout_reg <= timeout_next;
         instret_reg <= instret_next;
      end
   end

endmodule
